masked_sbox_array: RTL and testbench

MASKED_SBOX_ARRAY -- requirements
Module: masked_sbox_array

---
 rtl/masked_sbox_pkg.sv | 70 +++++++
 rtl/masked_sbox_lane.sv | 85 ++++++++
 rtl/masked_sbox_array.sv | 62 ++++++
 tb/tb_masked_sbox_array.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_sbox_pkg.sv
// Shared constants, types and GF(2^8) helpers for the two-share masked AES S-box array.
package masked_sbox_pkg;

   localparam int unsigned SBOX_LATENCY  = 3;
   localparam int unsigned RAND_PER_LANE = 32;
   localparam logic [7:0]  AFF_FWD_C     = 8'h63;
   localparam logic [7:0]  AFF_INV_C     = 8'h05;

   typedef enum logic {
      MODE_FWD = 1'b0,
      MODE_INV = 1'b1
   } sbox_mode_e;

   // Control bits that travel with each pipeline stage.
   typedef struct packed {
      logic       valid;
      sbox_mode_e mode;
   } stage_ctl_t;

   // One Boolean-masked byte: value = s0 ^ s1.
   typedef struct packed {
      logic [7:0] s1;
      logic [7:0] s0;
   } shares_t;

   // GF(2^8) multiply modulo the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] t;
      acc = '0;
      t   = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // Raise each share to 2^k independently; squaring is linear so shares never meet.
   function automatic shares_t sq_shares(input shares_t a, input int unsigned k);
      shares_t r;
      r = a;
      for (int unsigned i = 0; i < k; i++) begin
         r.s0 = gf_mul(r.s0, r.s0);
         r.s1 = gf_mul(r.s1, r.s1);
      end
      return r;
   endfunction

   // First-order PINI multiplication (HPC2 form over GF(2^8)) with one fresh byte r.
   // The cross product of share i only ever sees the other share masked by r,
   // and r is re-added so each output share stays uniformly masked.
   function automatic shares_t hpc_mul(input shares_t a, input shares_t b, input logic [7:0] r);
      shares_t c;
      c.s0 = gf_mul(a.s0, b.s0) ^ gf_mul(a.s0, b.s1 ^ r) ^ gf_mul(a.s0, r) ^ r;
      c.s1 = gf_mul(a.s1, b.s1) ^ gf_mul(a.s1, b.s0 ^ r) ^ gf_mul(a.s1, r) ^ r;
      return c;
   endfunction

   // Linear part of the forward AES affine map: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4.
   function automatic logic [7:0] aff_fwd_lin(input logic [7:0] x);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]};
   endfunction

   // Linear part of the inverse AES affine map: rotl1 ^ rotl3 ^ rotl6.
   function automatic logic [7:0] aff_inv_lin(input logic [7:0] x);
      return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]};
   endfunction

endpackage

// File: rtl/masked_sbox_lane.sv
// One byte lane: input affine, masked inversion, output affine, each ending in a register.
module masked_sbox_lane
   import masked_sbox_pkg::*;
#(
   parameter bit INV_EN = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  sbox_mode_e               in_mode,
   input  sbox_mode_e               mid_mode,
   input  logic [7:0]               in_share0,
   input  logic [7:0]               in_share1,
   input  logic [RAND_PER_LANE-1:0] ran,
   output logic [7:0]               out_share0,
   output logic [7:0]               out_share1
);

   shares_t s1_d, s2_d, s3_d;
   shares_t s1_q, s2_q, s3_q;
   shares_t x1, x2, x3, x12, x14, x15, x240, x254;

   if (INV_EN) begin : g_inv
      // Stage 1: inverse affine per share; the constant goes onto share 0 only.
      always_comb begin
         s1_d.s0 = in_share0;
         s1_d.s1 = in_share1;
         if (in_mode == MODE_INV) begin
            s1_d.s0 = aff_inv_lin(in_share0) ^ AFF_INV_C;
            s1_d.s1 = aff_inv_lin(in_share1);
         end
      end

      // Stage 3: forward affine per share for forward beats only.
      always_comb begin
         s3_d = s2_q;
         if (mid_mode == MODE_FWD) begin
            s3_d.s0 = aff_fwd_lin(s2_q.s0) ^ AFF_FWD_C;
            s3_d.s1 = aff_fwd_lin(s2_q.s1);
         end
      end
   end else begin : g_fwd
      // Stage 1: forward-only lanes pass the shares straight through.
      always_comb begin
         s1_d.s0 = in_share0;
         s1_d.s1 = in_share1;
      end

      // Stage 3: forward affine per share.
      always_comb begin
         s3_d.s0 = aff_fwd_lin(s2_q.s0) ^ AFF_FWD_C;
         s3_d.s1 = aff_fwd_lin(s2_q.s1);
      end
   end

   // Stage 2: masked inversion as x^254, four PINI multiplies, one random byte each.
   always_comb begin
      x1   = s1_q;
      x2   = sq_shares(x1, 1);
      x3   = hpc_mul(x2, x1, ran[7:0]);
      x12  = sq_shares(x3, 2);
      x15  = hpc_mul(x12, x3, ran[15:8]);
      x14  = hpc_mul(x12, x2, ran[23:16]);
      x240 = sq_shares(x15, 4);
      x254 = hpc_mul(x240, x14, ran[31:24]);
      s2_d = x254;
   end

   // Stage registers: cleared by reset, loaded together whenever the pipe advances.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else if (en) begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign out_share0 = s3_q.s0;
   assign out_share1 = s3_q.s1;

endmodule

// File: rtl/masked_sbox_array.sv
// Array of masked S-box lanes sharing one valid/ready pipeline controller.
module masked_sbox_array
   import masked_sbox_pkg::*;
#(
   parameter int unsigned LANES  = 4,
   parameter bit          INV_EN = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_mode,
   input  logic [8*LANES-1:0]               in_share0,
   input  logic [8*LANES-1:0]               in_share1,
   input  logic [RAND_PER_LANE*LANES-1:0]   ran,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [8*LANES-1:0]               out_share0,
   output logic [8*LANES-1:0]               out_share1
);

   stage_ctl_t ctl_q [SBOX_LATENCY];
   sbox_mode_e mode_in;
   logic       advance;

   assign mode_in   = INV_EN ? sbox_mode_e'(in_mode) : MODE_FWD;
   assign out_valid = ctl_q[SBOX_LATENCY-1].valid;
   assign advance   = !out_valid | out_ready;
   assign in_ready  = advance | rst;

   // Valid/mode shift register; an idle input cycle enters as a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < SBOX_LATENCY; i++) begin
            ctl_q[i] <= '{valid: 1'b0, mode: MODE_FWD};
         end
      end else if (advance) begin
         ctl_q[0] <= '{valid: in_valid, mode: mode_in};
         for (int unsigned i = 1; i < SBOX_LATENCY; i++) begin
            ctl_q[i] <= ctl_q[i-1];
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      masked_sbox_lane #(
         .INV_EN (INV_EN)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .en         (advance),
         .in_mode    (mode_in),
         .mid_mode   (ctl_q[1].mode),
         .in_share0  (in_share0[8*i +: 8]),
         .in_share1  (in_share1[8*i +: 8]),
         .ran        (ran[RAND_PER_LANE*i +: RAND_PER_LANE]),
         .out_share0 (out_share0[8*i +: 8]),
         .out_share1 (out_share1[8*i +: 8])
      );
   end

endmodule

// File: tb/tb_masked_sbox_array.sv
// Scoreboard bench for masked_sbox_array: directed beats, streaming, stall and reset.
module tb_masked_sbox_array;

   localparam int unsigned L = 4;
   localparam int unsigned W = 8 * L;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_mode = 1'b0;
   logic [W-1:0]  in_share0 = '0;
   logic [W-1:0]  in_share1 = '0;
   logic [32*L-1:0] ran = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_share0;
   logic [W-1:0]  out_share1;

   always #5 clk = ~clk;

   masked_sbox_array #(
      .LANES  (L),
      .INV_EN (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mode    (in_mode),
      .in_share0  (in_share0),
      .in_share1  (in_share1),
      .ran        (ran),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_share0 (out_share0),
      .out_share1 (out_share1)
   );

   typedef struct {
      logic [W-1:0] want;
      int           acc;
   } ent_t;

   ent_t       sb_q[$];
   logic [7:0] obs_q[$];
   int         n_vec = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         last_stall = -1;
   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, want);
      end
   endtask

   // Reference model: inverse by exhaustive search, affine map written bit by bit.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      while (bb != 8'h00) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      logic [7:0] c, s;
      c = 8'h63;
      for (int i = 0; i < 8; i++)
         s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      return s;
   endfunction

   function automatic logic [W-1:0] model(input logic mode, input logic [W-1:0] x);
      logic [W-1:0] e;
      for (int i = 0; i < L; i++)
         e[8*i +: 8] = mode ? isb[x[8*i +: 8]] : sb[x[8*i +: 8]];
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_w();
      logic [W-1:0] v;
      for (int i = 0; i < L; i++) v[8*i +: 8] = 8'($urandom);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < L; i++) ran[32*i +: 32] = $urandom;
   endtask

   // Present one beat, push its expectation at the cycle it is accepted.
   task automatic drive(input logic mode, input logic [W-1:0] s0, input logic [W-1:0] s1,
                        input logic [W-1:0] want);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1; in_mode = mode; in_share0 = s0; in_share1 = s1;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back('{want: want, acc: cyc});
            ok = 1'b1;
         end
         step();
      end
      if (!ok) chk("accept", W'(in_ready), W'(1));
      in_valid = 1'b0;
   endtask

   task automatic dbeat(input logic mode, input logic [W-1:0] x, input logic [W-1:0] want);
      logic [W-1:0] m;
      m = rnd_w();
      drive(mode, m, m ^ x, want);
   endtask

   task automatic rbeat(input logic mode);
      logic [W-1:0] x;
      x = rnd_w();
      dbeat(mode, x, model(mode, x));
   endtask

   task automatic drain();
      for (int t = 0; t < 20 && sb_q.size() > 0; t++) step();
      repeat (3) step();
      chk("drain", W'(sb_q.size()), W'(0));
   endtask

   // Output monitor: pops the scoreboard on every handshake, tracks stall cycles.
   always @(negedge clk) begin
      ent_t e;
      if (!rst && out_valid && !out_ready) last_stall = cyc;
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("spurious", W'(out_valid), W'(0));
         end else begin
            e = sb_q.pop_front();
            chk("unmask", out_share0 ^ out_share1, e.want);
            if (e.acc > last_stall) chk("latency", W'(cyc - e.acc), W'(3));
            obs_q.push_back(out_share0[7:0]);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] snap0, snap1, x, s0;
      int idx;

      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sb[a] = affine(inv);
      end
      for (int a = 0; a < 256; a++) isb[sb[a]] = 8'(a);

      // Reset state, with in_ready required high during reset.
      repeat (2) begin
         @(negedge clk);
         chk("rst_valid", W'(out_valid), W'(0));
         chk("rst_sh0", out_share0, '0);
         chk("rst_sh1", out_share1, '0);
         chk("rst_ready", W'(in_ready), W'(1));
         step();
      end
      rst = 1'b0;
      out_ready = 1'b1;
      step();

      // Forward known answers.
      dbeat(1'b0, 32'hFF_53_01_00, 32'h16_ED_7C_63);
      drain();

      // Inverse known answers, then mixed-mode back-to-back stream.
      dbeat(1'b1, 32'h16_7C_ED_63, 32'hFF_01_53_00);
      rbeat(1'b0);
      rbeat(1'b1);
      rbeat(1'b0);
      drain();

      // Random stream with occasional bubbles.
      for (int i = 0; i < 16; i++) begin
         rbeat(1'($urandom));
         if ($urandom_range(0, 3) == 0) step();
      end
      drain();

      // Backpressure with the pipe full: five stalled cycles, inputs ignored.
      rbeat(1'b0);
      rbeat(1'b1);
      rbeat(1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ready", W'(in_ready), W'(0));
         chk("stall_valid", W'(out_valid), W'(1));
         if (i == 0) begin
            snap0 = out_share0;
            snap1 = out_share1;
         end else begin
            chk("stall_sh0", out_share0, snap0);
            chk("stall_sh1", out_share1, snap1);
         end
         step();
         in_valid = 1'b1;
         in_mode = 1'($urandom);
         in_share0 = rnd_w();
         in_share1 = rnd_w();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // Reset with two beats in flight; a beat offered during reset must be dropped.
      rbeat(1'b0);
      rbeat(1'b1);
      rst = 1'b1;
      in_valid = 1'b1;
      in_share0 = rnd_w();
      in_share1 = rnd_w();
      @(negedge clk);
      chk("rst_mid_ready", W'(in_ready), W'(1));
      step();
      sb_q.delete();
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", W'(out_valid), W'(0));
      chk("rst_mid_sh0", out_share0, '0);
      chk("rst_mid_sh1", out_share1, '0);
      repeat (6) begin
         step();
         @(negedge clk);
         chk("stale", W'(out_valid), W'(0));
      end
      step();

      // Same secret 0x53 in lane 0 under two different share splits.
      idx = obs_q.size();
      x = rnd_w();
      x[7:0] = 8'h53;
      s0 = rnd_w();
      s0[7:0] = 8'hA5;
      drive(1'b0, s0, s0 ^ x, model(1'b0, x));
      x = rnd_w();
      x[7:0] = 8'h53;
      s0 = rnd_w();
      s0[7:0] = 8'h00;
      drive(1'b0, s0, s0 ^ x, model(1'b0, x));
      drain();
      if (obs_q.size() < idx + 2) begin
         chk("mask_cnt", W'(obs_q.size()), W'(idx + 2));
      end else begin
         n_vec++;
         assert (obs_q[idx] !== obs_q[idx+1]) else begin
            n_bad++;
            $error("FAIL mask_diff: got %h and %h want different", obs_q[idx], obs_q[idx+1]);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
